// File: rtl/cpubus_pkg.sv
// Shared definitions for the byte-serial CPU bus (pin handler and memory side).
package cpubus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BEAT_W         = 3;
  localparam int unsigned BEATS_PER_HALF = 4;
  localparam int unsigned FRAME_CYCLES   = 9;
  localparam logic        RW_WRITE       = 1'b1;

  // Fully assembled request as seen at the commit edge of a frame.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              rw;
  } cpubus_req_t;

endpackage

// File: rtl/cpubus_word_ram.sv
// Word-wide register-array memory: asynchronous read, synchronous write, no reset.
module cpubus_word_ram #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_c_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Combinational read of the addressed word.
  assign rdata_c_o = mem_q[idx_i];

  // Word write on the commit edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/cpubus_mem_responder.sv
// Memory-side endpoint of the byte-serial CPU bus: framing FSM, byte assembler,
// read-response shifter, and a word RAM behind a base-address window.
module cpubus_mem_responder
  import cpubus_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MISS_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_sync_i,
  input  logic              bus_rw_i,
  input  logic [BYTE_W-1:0] bus_addr_i,
  input  logic [BYTE_W-1:0] bus_data_i,
  output logic [BYTE_W-1:0] bus_data_o,
  output logic              bus_data_oe_o,
  output logic              busy_o,
  output logic              miss_o,
  output logic              sync_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CAP_W = (BEATS_PER_HALF - 1) * BYTE_W;
  localparam logic [WORD_W-1:0] WIN_MASK = WORD_W'(DEPTH * 4 - 1);
  localparam logic [BEAT_W-1:0] LAST_ADDR_BEAT = BEAT_W'(BEATS_PER_HALF - 1);
  localparam logic [BEAT_W-1:0] LAST_RESP_BEAT = BEAT_W'(2 * BEATS_PER_HALF - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                rw_q, rw_d;
  logic [CAP_W-1:0]    addr_q, addr_d;
  logic [CAP_W-1:0]    wd_q, wd_d;
  logic [CAP_W-1:0]    rsh_q, rsh_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                miss_q, miss_d;
  logic                serr_q, serr_d;

  cpubus_req_t         req_c;
  logic                hit_c;
  logic [IDX_W-1:0]    idx_c;
  logic                mem_we_c;
  logic [WORD_W-1:0]   ram_rdata_c;
  logic [WORD_W-1:0]   rd_word_c;

  // Full request formed from the three captured bytes plus the live fourth beat.
  always_comb begin
    req_c.addr  = {bus_addr_i, addr_q};
    req_c.wdata = {bus_data_i, wd_q};
    req_c.rw    = rw_q;
  end

  // Window decode; the low two address bits are dropped so bytes alias to their word.
  assign hit_c     = (req_c.addr & ~WIN_MASK) == BASE_ADDR;
  assign idx_c     = req_c.addr[2 +: IDX_W];
  assign rd_word_c = hit_c ? ram_rdata_c : MISS_DATA;

  cpubus_word_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_ram (
    .clk       (clk),
    .we_i      (mem_we_c),
    .idx_i     (idx_c),
    .wdata_i   (req_c.wdata),
    .rdata_c_o (ram_rdata_c)
  );

  // State, beat counter, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rsh_q   <= '0;
      data_q  <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      miss_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rsh_q   <= rsh_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      miss_q  <= miss_d;
      serr_q  <= serr_d;
    end
  end

  // Framing FSM: beats 0..3 assemble the request, beats 4..7 stream the response.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rsh_d    = rsh_q;
    data_d   = '0;
    oe_d     = oe_q;
    busy_d   = busy_q;
    miss_d   = 1'b0;
    serr_d   = 1'b0;
    mem_we_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_sync_i) begin
          state_d = ADDR;
          beat_d  = '0;
          busy_d  = 1'b1;
        end
      end

      ADDR: begin
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == '0) begin
          rw_d = bus_rw_i;
        end
        if (beat_q == LAST_ADDR_BEAT) begin
          // Commit edge: perform the write or load the response word.
          state_d = RESP;
          miss_d  = !hit_c;
          if (req_c.rw == RW_WRITE) begin
            mem_we_c = hit_c;
          end else begin
            oe_d   = 1'b1;
            data_d = rd_word_c[BYTE_W-1:0];
            rsh_d  = rd_word_c[WORD_W-1:BYTE_W];
          end
        end else begin
          case (beat_q[1:0])
            2'd0: begin
              addr_d[0*BYTE_W +: BYTE_W] = bus_addr_i;
              wd_d[0*BYTE_W +: BYTE_W]   = bus_data_i;
            end
            2'd1: begin
              addr_d[1*BYTE_W +: BYTE_W] = bus_addr_i;
              wd_d[1*BYTE_W +: BYTE_W]   = bus_data_i;
            end
            2'd2: begin
              addr_d[2*BYTE_W +: BYTE_W] = bus_addr_i;
              wd_d[2*BYTE_W +: BYTE_W]   = bus_data_i;
            end
            default: ;
          endcase
        end
      end

      RESP: begin
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == LAST_RESP_BEAT) begin
          state_d = IDLE;
          beat_d  = '0;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (oe_q) begin
          data_d = rsh_q[BYTE_W-1:0];
          rsh_d  = {BYTE_W'(0), rsh_q[CAP_W-1:BYTE_W]};
        end
      end

      default: begin
        state_d = IDLE;
        beat_d  = '0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A sync while busy aborts the frame (before any write commits) and restarts at T1.
    if (busy_q && frame_sync_i) begin
      state_d  = ADDR;
      beat_d   = '0;
      data_d   = '0;
      oe_d     = 1'b0;
      busy_d   = 1'b1;
      miss_d   = 1'b0;
      serr_d   = 1'b1;
      mem_we_c = 1'b0;
    end
  end

  assign bus_data_o    = data_q;
  assign bus_data_oe_o = oe_q;
  assign busy_o        = busy_q;
  assign miss_o        = miss_q;
  assign sync_err_o    = serr_q;

endmodule

// File: tb/tb_cpubus_mem_responder.sv
// Directed bench for cpubus_mem_responder: frame table plus abort/reset sequences.
module tb_cpubus_mem_responder;
  import cpubus_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       frame_sync;
  logic       bus_rw;
  logic [7:0] bus_addr;
  logic [7:0] bus_data;
  logic [7:0] data_o;
  logic       oe;
  logic       busy;
  logic       miss;
  logic       serr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        miss;
  } vec_t;

  vec_t vecs[13];

  cpubus_mem_responder #(
    .DEPTH     (64),
    .BASE_ADDR (32'h0000_0000),
    .MISS_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_sync_i  (frame_sync),
    .bus_rw_i      (bus_rw),
    .bus_addr_i    (bus_addr),
    .bus_data_i    (bus_data),
    .bus_data_o    (data_o),
    .bus_data_oe_o (oe),
    .busy_o        (busy),
    .miss_o        (miss),
    .sync_err_o    (serr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_oe"},   32'(oe),     32'd0);
    chk({tag, "_data"}, 32'(data_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy),   32'd0);
    chk({tag, "_miss"}, 32'(miss),   32'd0);
    chk({tag, "_serr"}, 32'(serr),   32'd0);
  endtask

  // One frame from T0 (or from T1 right after an abort) through T8; checks every cycle.
  task automatic do_frame(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input logic exp_miss, input logic abort);
    logic [31:0] av, dv, ev;
    av = a; dv = d; ev = exp;
    if (!abort) begin
      frame_sync = 1'b1;
      bus_rw     = rw;
      @(negedge clk);
      chk("t0_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      frame_sync = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      bus_rw   = rw;
      bus_addr = av[8*k +: 8];
      bus_data = dv[8*k +: 8];
      @(negedge clk);
      chk("addr_busy", 32'(busy),   32'd1);
      chk("addr_oe",   32'(oe),     32'd0);
      chk("addr_data", 32'(data_o), 32'd0);
      chk("addr_miss", 32'(miss),   32'd0);
      chk("addr_serr", 32'(serr),   32'(abort && k == 0));
      @(posedge clk); #1;
    end
    bus_addr = 8'h00;
    bus_data = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("resp_busy", 32'(busy),   32'd1);
      chk("resp_oe",   32'(oe),     32'(!rw));
      chk("resp_data", 32'(data_o), rw ? 32'd0 : 32'(ev[8*k +: 8]));
      chk("resp_miss", 32'(miss),   32'(exp_miss && k == 0));
      chk("resp_serr", 32'(serr),   32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Starts a frame and raises a second sync in cycle T<cyc>; returns at new T1.
  task automatic start_and_abort(input logic rw, input logic [31:0] a, input logic [31:0] d,
                                 input int cyc);
    logic [31:0] av, dv;
    av = a; dv = d;
    frame_sync = 1'b1;
    bus_rw     = rw;
    @(posedge clk); #1;
    for (int c = 1; c <= cyc; c++) begin
      if (c <= 4) begin
        bus_addr = av[8*(c-1) +: 8];
        bus_data = dv[8*(c-1) +: 8];
      end else begin
        bus_addr = 8'h00;
        bus_data = 8'h00;
      end
      frame_sync = (c == cyc);
      @(negedge clk);
      chk("pre_abort_busy", 32'(busy), 32'd1);
      chk("pre_abort_serr", 32'(serr), 32'd0);
      @(posedge clk); #1;
    end
    frame_sync = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_sync = 1'b0;
    bus_rw     = 1'b0;
    bus_addr   = 8'h00;
    bus_data   = 8'h00;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hA1B2_C3D4, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,          32'hA1B2_C3D4, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,          1'b0};
    vecs[4]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 32'h0,          1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0BAD_F00D, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_00FC, 32'h1122_3344, 32'h0,          1'b0};
    vecs[7]  = '{1'b0, 32'h0000_00FF, 32'h0,          32'h1122_3344, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,          1'b0};
    vecs[10] = '{1'b1, 32'h0000_0080, 32'h5566_7788, 32'h0,          1'b0};
    vecs[11] = '{1'b0, 32'h0000_0080, 32'h0,          32'h5566_7788, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0012, 32'h0,          32'hA1B2_C3D4, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table frames, issued back to back at the minimum FRAME_CYCLES period.
    for (int i = 0; i < 13; i++) begin
      do_frame(vecs[i].rw, vecs[i].addr, vecs[i].wd, vecs[i].exp, vecs[i].miss, 1'b0);
    end

    // Sync at T3 of a write to 0x20: write dropped, new read frame starts at T4.
    start_and_abort(1'b1, 32'h0000_0020, 32'h9999_9999, 3);
    do_frame(1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);

    // Sync at T4 of a write: the commit edge is overridden, nothing written.
    start_and_abort(1'b1, 32'h0000_0080, 32'h7777_7777, 4);
    do_frame(1'b0, 32'h0000_0080, 32'h0, 32'h5566_7788, 1'b0, 1'b1);

    // Sync at T6 of a read: response stops, new write frame proceeds.
    start_and_abort(1'b0, 32'h0000_0010, 32'h0, 6);
    do_frame(1'b1, 32'h0000_0084, 32'h0F0E_0D0C, 32'h0, 1'b0, 1'b1);
    do_frame(1'b0, 32'h0000_0084, 32'h0, 32'h0F0E_0D0C, 1'b0, 1'b0);

    // Reset asserted in T6 of a read frame.
    frame_sync = 1'b1;
    bus_rw     = 1'b0;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_addr = (k == 0) ? 8'h10 : 8'h00;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_pre_t5_data", 32'(data_o), 32'h0000_00D4);
    @(posedge clk); #1;
    chk("rst_pre_t6_oe", 32'(oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("midreset");
    @(negedge clk);
    chk_idle("midreset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("post_reset");
    @(posedge clk); #1;
    do_frame(1'b0, 32'h0000_0010, 32'h0, 32'hA1B2_C3D4, 1'b0, 1'b0);

    @(negedge clk);
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpubus_mem_responder.md
Name: cpubus_mem_responder

Overview:
- Memory-side endpoint of the 8-bit byte-serial CPU bus used by the core's pin handler.
- Deserializes a 32-bit address and 32-bit write data, sent LSB byte first over four beats, and performs a word write or read on an internal register-array memory.
- For read frames, serializes the 32-bit read word back over four response beats.
- Sits in the FPGA/test harness as the partner of the CPU pin handler, or on-chip as a loopback memory model.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, ≥4.
- BASE_ADDR, 32'h0000_0000, byte base of the window; aligned to DEPTH*4.
- MISS_DATA, 32'hDEAD_BEEF, word returned for out-of-window reads.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_sync_i  in  1  high for one cycle (T0) when the initiator starts a frame.
- bus_rw_i  in  1  1 = write frame, 0 = read frame; sampled at T1, stable for the frame.
- bus_addr_i  in  8  address byte k valid in cycle T(k+1), k = 0..3.
- bus_data_i  in  8  write-data byte k valid in cycle T(k+1); ignored on read frames.
- bus_data_o  out  8  read-data byte k driven in cycle T(k+5).
- bus_data_oe_o  out  1  high only during T5..T8 of read frames.
- busy_o  out  1  high from T1 through T8.
- miss_o  out  1  one-cycle pulse in T5 when the address is outside the window.
- sync_err_o  out  1  one-cycle pulse when a sync arrives mid-frame.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; beat counter 0; memory contents not reset (undefined until written).
- FSM states: IDLE, ADDR (beats 1..4), RESP (beats 5..8). 3-bit beat counter.
- IDLE:
  - frame_sync_i=1 -> ADDR next cycle (T1), busy_o=1.
- ADDR:
  - Edges ending T1..T3 capture addr byte k into addr[8k+7:8k] and data byte k into wd[8k+7:8k].
  - rw is captured at the edge ending T1.
- Edge ending T4:
  - Forms full addr/wd from the captured bytes plus the live byte 3.
  - hit = (addr & ~(DEPTH*4-1)) == BASE_ADDR.
  - idx = addr[2 +: log2(DEPTH)]; addr[1:0] is ignored, so unaligned addresses alias to their word.
  - Write frame: if hit, mem[idx] <= wd; if miss, the write is dropped.
  - Read frame: rsh <= hit ? mem[idx] : MISS_DATA; bus_data_o <= byte 0; bus_data_oe_o <= 1.
  - miss_o <= !hit for one cycle.
  - FSM -> RESP.
- RESP:
  - Edges ending T5, T6, T7 present bytes 1, 2, 3 on bus_data_o.
  - Edge ending T8: bus_data_o <= 0, oe <= 0, busy <= 0, FSM -> IDLE.
  - Write frames: oe stays 0 and data_o stays 0 throughout RESP.
- Write-then-read: a write at T4 is visible to any read frame that starts after it.
- Earliest legal next sync is T9 (back-to-back frames, 9-cycle period).
- frame_sync_i while busy (T1..T8):
  - sync_err_o pulses the next cycle.
  - The current frame is aborted; a write not yet committed (sync at or before T4) is not performed.
  - oe and data_o clear; the next cycle is treated as T1 of a new frame.
- Asynchronous reset mid-frame: immediate return to the reset state; no memory write occurs after assertion.
- Byte order is always LSB first; there are no wait states, so response latency is fixed.

Decomposition:
- Shared package cpubus_pkg holds:
  - state enum {IDLE, ADDR, RESP};
  - BEATS_PER_HALF=4, FRAME_CYCLES=9;
  - RW_WRITE=1'b1.
- The CPU-side pin handler also uses this package.
- One sub-module: cpubus_word_ram (DEPTH x 32 register array, asynchronous read, synchronous write-enable, no reset).
- Framing FSM, byte assembler and output shifter stay in the top module.

Test Plan:
- Reset: assert rst_n low at T6 of a read frame -> oe=0, data_o=0, busy=0, no pulses; the next frame behaves normally.
- Write 0x0000_0010 <- 0xA1B2_C3D4, then read 0x0000_0010 -> bytes D4,C3,B2,A1 on T5..T8 with oe=1 only in T5..T8, miss_o=0.
- Read 0x0000_1000 (DEPTH=64) -> EF,BE,AD,DE with miss_o pulse in T5. A write to 0x1000 followed by a read of 0x0000_0000 (word index 0 of 0x1000) returns the old word unchanged.
- Sync at T3 of a write frame to 0x20 -> sync_err_o pulse at T4; mem[8] not written; the new frame starting at T4 completes correctly.
- Edges: write 0xFC = 0x1122_3344, read 0xFF -> 44,33,22,11 (alias); read 0x100 -> miss.
- Back-to-back: three frames with sync at T0, T9, T18 (write, read, read) -> correct data each frame; busy low only in the sync cycles.
